// File: rtl/syslatch_pkg.sv
// Shared definitions for the system-latch writer: latch bit indices and FSM state encoding.
package syslatch_pkg;

    localparam logic [2:0] SHADOW     = 3'd0;
    localparam logic [2:0] nVEC       = 3'd1;
    localparam logic [2:0] nCARDWEN   = 3'd2;
    localparam logic [2:0] CARDWENB   = 3'd3;
    localparam logic [2:0] nREGEN     = 3'd4;
    localparam logic [2:0] nSYSTEM    = 3'd5;
    localparam logic [2:0] nSRAMWEN_b = 3'd6;
    localparam logic [2:0] PALBNK     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_FIN
    } state_t;

endpackage

// File: rtl/syslatch_writer_if.sv
// Request handshake and latch bus between a requester and the system-latch writer.
interface syslatch_writer_if;

    logic       REQ;
    logic [7:0] TARGET;
    logic       FORCE;
    logic [4:1] M68K_ADDR;
    logic       nBITW1;
    logic       BUSY;
    logic       DONE;
    logic [7:0] MIRROR;

    modport master (
        output REQ, TARGET, FORCE,
        input  M68K_ADDR, nBITW1, BUSY, DONE, MIRROR
    );

    modport slave (
        input  REQ, TARGET, FORCE,
        output M68K_ADDR, nBITW1, BUSY, DONE, MIRROR
    );

endinterface

// File: rtl/syslatch_writer.sv
// Programs the 8-bit system latch one bit at a time, skipping bits whose mirror already matches.
module syslatch_writer
    import syslatch_pkg::*;
#(
    parameter int STROBE_LEN = 2
) (
    input  logic             CLK_24M,
    input  logic             RESET,
    syslatch_writer_if.slave bus
);

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_LEN - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] target_q, target_d;
    logic       force_q, force_d;
    logic [7:0] mirror_q, mirror_d;
    logic [4:1] addr_c;
    logic       nbitw1_c;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            force_q  <= 1'b0;
            mirror_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            force_q  <= force_d;
            mirror_q <= mirror_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = '0;
        target_d = target_q;
        force_d  = force_q;
        mirror_d = mirror_q;
        addr_c   = '0;
        nbitw1_c = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    target_d = bus.TARGET;
                    force_d  = bus.FORCE;
                    idx_d    = '0;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (force_q || (target_q[idx_q] != mirror_q[idx_q])) begin
                    state_d = ST_SETUP;
                end else if (idx_q == PALBNK) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_SETUP: begin
                addr_c  = {target_q[idx_q], idx_q};
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                addr_c   = {target_q[idx_q], idx_q};
                nbitw1_c = 1'b0;
                if (cnt_q == STROBE_LAST) begin
                    // The latch holds the new bit once the strobe ends.
                    mirror_d[idx_q] = target_q[idx_q];
                    state_d         = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HOLD: begin
                addr_c = {target_q[idx_q], idx_q};
                if (idx_q == PALBNK) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_EVAL;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.M68K_ADDR = addr_c;
    assign bus.nBITW1    = nbitw1_c;
    assign bus.BUSY      = (state_q != ST_IDLE);
    assign bus.DONE      = (state_q == ST_FIN);
    assign bus.MIRROR    = mirror_q;

endmodule

// File: tb/tb_syslatch_writer.sv
// Directed and random checks of syslatch_writer against a bus-level model of the system latch.
module tb_syslatch_writer;

    localparam int SL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    syslatch_writer_if sw_if ();

    syslatch_writer #(.STROBE_LEN(SL)) dut (
        .CLK_24M (clk),
        .RESET   (rst),
        .bus     (sw_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the physical latch: cleared in reset, written while the strobe is low.
    logic [7:0] latch = 8'h00;
    always @(posedge clk) begin
        if (rst) latch <= 8'h00;
        else if (sw_if.nBITW1 === 1'b0) latch[sw_if.M68K_ADDR[3:1]] <= sw_if.M68K_ADDR[4];
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_mirror  = 8'h00;
    int         lowcnt;
    bit         addr_moved;
    logic [4:1] strobe_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_mirror = 8'h00;
    endtask

    // Watches the bus until DONE; optionally pulses REQ with a different image while busy.
    task automatic wait_done(input bit pulse, output int lat, output bit got);
        int         n0;
        bit         prev_low;
        logic [4:1] prev_addr;
        n0         = cyc;
        lowcnt     = 0;
        addr_moved = 1'b0;
        strobe_q.delete();
        prev_low   = 1'b0;
        prev_addr  = '0;
        got        = 1'b0;
        lat        = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (pulse && k == 1) begin
                sw_if.REQ    = 1'b1;
                sw_if.TARGET = ~sw_if.TARGET;
                sw_if.FORCE  = 1'b1;
            end else if (pulse && k == 2) begin
                sw_if.REQ = 1'b0;
            end
            if (sw_if.nBITW1 === 1'b0) begin
                lowcnt++;
                if (prev_low && sw_if.M68K_ADDR !== prev_addr) addr_moved = 1'b1;
                if (!prev_low) strobe_q.push_back(sw_if.M68K_ADDR);
                prev_addr = sw_if.M68K_ADDR;
                prev_low  = 1'b1;
            end else begin
                prev_low = 1'b0;
            end
            if (sw_if.DONE === 1'b1) begin
                got = 1'b1;
                lat = cyc - n0;
                break;
            end
        end
    endtask

    task automatic do_req(input logic [7:0] tgt, input logic frc, input bit pulse);
        int w, lat;
        bit got;
        w = frc ? 8 : $countones(tgt ^ exp_mirror);
        @(negedge clk);
        sw_if.REQ    = 1'b1;
        sw_if.TARGET = tgt;
        sw_if.FORCE  = frc;
        @(negedge clk);
        sw_if.REQ    = 1'b0;
        sw_if.TARGET = 8'($urandom);
        sw_if.FORCE  = 1'($urandom);
        check("busy_on_accept", 32'(sw_if.BUSY), 32'd1);
        wait_done(pulse, lat, got);
        check("done_seen", 32'(got), 32'd1);
        check("done_latency", 32'(lat), 32'(8 + w * (2 + SL)));
        check("strobe_cycles", 32'(lowcnt), 32'(w * SL));
        check("addr_stable", 32'(addr_moved), 32'd0);
        check("mirror", 32'(sw_if.MIRROR), 32'(tgt));
        check("latch_vs_mirror", 32'(latch), 32'(sw_if.MIRROR));
        exp_mirror = tgt;
        @(negedge clk);
        check("done_one_cycle", 32'(sw_if.DONE), 32'd0);
        check("busy_drop", 32'(sw_if.BUSY), 32'd0);
    endtask

    initial begin
        int  lat, dones, busys;
        bit  got, ok;
        sw_if.REQ    = 1'b0;
        sw_if.TARGET = 8'h00;
        sw_if.FORCE  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_mirror", 32'(sw_if.MIRROR), 32'h00);
        check("rst_busy", 32'(sw_if.BUSY), 32'd0);
        check("rst_done", 32'(sw_if.DONE), 32'd0);
        check("rst_nbitw1", 32'(sw_if.nBITW1), 32'd1);
        check("rst_addr", 32'(sw_if.M68K_ADDR), 32'h0);

        // Single bit 0 write
        do_req(8'h01, 1'b0, 1'b0);
        check("b0_strobes", 32'(strobe_q.size()), 32'd1);
        if (strobe_q.size() > 0) check("b0_addr", 32'(strobe_q[0]), 32'b1000);

        // Matching image: nothing written
        do_req(8'h5A, 1'b0, 1'b0);
        do_req(8'h5A, 1'b0, 1'b0);
        check("match_strobes", 32'(strobe_q.size()), 32'd0);

        // Forced write of all-zero image: eight ascending strobes
        do_req(8'h00, 1'b0, 1'b0);
        do_req(8'h00, 1'b1, 1'b0);
        ok = (strobe_q.size() == 8);
        foreach (strobe_q[i]) ok &= (strobe_q[i] == {1'b0, 3'(i)});
        check("force_indices", 32'(ok), 32'd1);

        // Bit 7 only, with a REQ pulse while busy that must be ignored
        do_req(8'h80, 1'b0, 1'b1);
        check("b7_strobes", 32'(strobe_q.size()), 32'd1);
        if (strobe_q.size() > 0) check("b7_addr", 32'(strobe_q[0]), 32'b1111);
        dones = 0;
        busys = 0;
        repeat (30) begin
            @(negedge clk);
            dones += int'(sw_if.DONE === 1'b1);
            busys += int'(sw_if.BUSY === 1'b1);
        end
        check("ignored_req_done", 32'(dones), 32'd0);
        check("ignored_req_busy", 32'(busys), 32'd0);

        // Reset in the middle of a strobe
        @(negedge clk);
        sw_if.REQ = 1'b1; sw_if.TARGET = 8'hFF; sw_if.FORCE = 1'b1;
        @(negedge clk);
        sw_if.REQ = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (sw_if.nBITW1 === 1'b0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("strobe_reached", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_nbitw1", 32'(sw_if.nBITW1), 32'd1);
        check("abort_mirror", 32'(sw_if.MIRROR), 32'h00);
        check("abort_busy", 32'(sw_if.BUSY), 32'd0);
        rst = 1'b0;
        exp_mirror = 8'h00;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            dones += int'(sw_if.DONE === 1'b1);
        end
        check("abort_no_done", 32'(dones), 32'd0);
        check("abort_latch", 32'(latch), 32'h00);

        // Back-to-back: REQ held high through FIN
        sw_if.REQ = 1'b1; sw_if.TARGET = 8'h03; sw_if.FORCE = 1'b0;
        @(negedge clk);
        wait_done(1'b0, lat, got);
        check("b2b_first_done", 32'(got), 32'd1);
        check("b2b_first_lat", 32'(lat), 32'(8 + 2 * (2 + SL)));
        @(negedge clk);
        check("b2b_idle_gap", 32'(sw_if.BUSY), 32'd0);
        @(negedge clk);
        check("b2b_restart", 32'(sw_if.BUSY), 32'd1);
        sw_if.REQ = 1'b0;
        wait_done(1'b0, lat, got);
        check("b2b_second_done", 32'(got), 32'd1);
        check("b2b_second_lat", 32'(lat), 32'd8);
        exp_mirror = 8'h03;
        check("b2b_mirror", 32'(sw_if.MIRROR), 32'h03);

        // Random requests
        for (int n = 0; n < 200; n++) begin
            do_req(8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/syslatch_writer.md
SYSLATCH_WRITER -- requirements
Module: syslatch_writer

Interface
REQ-001 Parameter STROBE_LEN, default 2, sets the number of cycles nBITW1 is held low per bit write; legal range 1..15.
REQ-002 CLK_24M  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK_24M.
REQ-004 REQ  input  1  request to program the system latch; sampled only in IDLE.
REQ-005 TARGET  input  8  desired latch image, bit i = latch output i (0 SHADOW … 7 PALBNK).
REQ-006 FORCE  input  1  when high at acceptance, write all 8 bits regardless of mirror.
REQ-007 M68K_ADDR  output  4 [4:1]  bus address to latch; [4] = bit value, [3:1] = bit index.
REQ-008 nBITW1  output  1  active-low bit-write strobe to latch.
REQ-009 BUSY  output  1  high whenever state is not IDLE.
REQ-010 DONE  output  1  one-cycle pulse when a request completes.
REQ-011 MIRROR  output  8  writer's copy of the latch contents.

Function
REQ-012 FSM states: IDLE, EVAL, SETUP, STROBE, HOLD, FIN.
REQ-013 IDLE: on REQ=1, capture TARGET and FORCE into registers, clear index to 0, go to EVAL; otherwise stay.
REQ-014 EVAL (1 cycle per index): if FORCE_q=1 or TARGET_q[idx]≠MIRROR[idx], go to SETUP; else if idx=7 go to FIN; else increment idx and stay in EVAL.
REQ-015 SETUP: exactly 1 cycle; M68K_ADDR={TARGET_q[idx], idx}; nBITW1=1.
REQ-016 STROBE: exactly STROBE_LEN cycles; address held; nBITW1=0.
REQ-017 MIRROR[idx] takes TARGET_q[idx] on the edge leaving STROBE.
REQ-018 HOLD: exactly 1 cycle; address held; nBITW1=1; then FIN if idx=7, else increment idx and go to EVAL.
REQ-019 FIN: DONE=1 for this single cycle; next state IDLE.
REQ-020 Outside SETUP/STROBE/HOLD: M68K_ADDR=4'h0 and nBITW1=1.
REQ-021 Request accepted at edge N: BUSY high from cycle N+1; DONE in cycle N+9+W*(2+STROBE_LEN), W = number of bits written; BUSY low the following cycle.
REQ-022 REQ while BUSY is ignored and is not queued; TARGET/FORCE changes while BUSY have no effect.
REQ-023 REQ held high through FIN starts a new request on the first IDLE cycle (back-to-back allowed).
REQ-024 Index does not wrap: exactly indices 0..7 per request, ascending.
REQ-025 Only one bit is written per strobe; address never changes while nBITW1=0.

Reset
REQ-026 On RESET: state=IDLE, idx=0, TARGET_q=0, FORCE_q=0, MIRROR=8'h00, M68K_ADDR=4'h0, nBITW1=1, BUSY=0, DONE=0.
REQ-027 RESET mid-write aborts immediately; nBITW1 is high from the next cycle; the aborted request produces no DONE.
REQ-028 MIRROR reset value 8'h00 matches the latch being cleared while the system is in reset.

Structure
REQ-029 Shared package syslatch_pkg holds the bit-index constants (SHADOW=0, nVEC=1, nCARDWEN=2, CARDWENB=3, nREGEN=4, nSYSTEM=5, nSRAMWEN_b=6, PALBNK=7) and the FSM state encoding.
REQ-030 No sub-module; the strobe-length counter, the index counter and the FSM stay in syslatch_writer.

Verification
REQ-031 Reset, then REQ with TARGET=8'h01, FORCE=0, STROBE_LEN=2 -> one strobe with M68K_ADDR=4'b1000 for 2 cycles, DONE at N+13, MIRROR=8'h01.
REQ-032 MIRROR=8'h5A, REQ with TARGET=8'h5A, FORCE=0 -> no nBITW1 low, DONE at N+9.
REQ-033 MIRROR=8'h00, REQ with TARGET=8'h00, FORCE=1 -> 8 strobes, indices 0..7, M68K_ADDR[4]=0, DONE at N+41.
REQ-034 REQ with TARGET=8'h80 -> single write at index 7 with address 4'b1111; REQ pulsed while BUSY -> ignored, exactly one DONE.
REQ-035 RESET asserted during STROBE -> nBITW1=1 the next cycle, MIRROR=8'h00, no DONE.
REQ-036 Bench model of the system latch driven by M68K_ADDR/nBITW1 -> latch image equals MIRROR after every DONE across 200 random TARGET/FORCE requests.
